dmem_hs: RTL and testbench
==========================

DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 Parameter DEPTH, default 512: memory depth in 32-bit words; power of two, range 16 to 65536.
REQ-002 Parameter ADDR_W, default 32: request byte-address width; SHALL be at least clog2(DEPTH)+2.
REQ-003 Parameter LATENCY, default 1: request-accept to response-valid latency in cycles; range 1 to 4.
REQ-004 Port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port i_reset, input, 1: asynchronous, active-low reset.
REQ-006 Port i_req_valid, input, 1: request present.
REQ-007 Port o_req_ready, output, 1: block can accept a request.
REQ-008 Port i_req_we, input, 1: 1 = store, 0 = load.
REQ-009 Port i_req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 Port i_req_unsigned, input, 1: load zero-extends when 1, sign-extends when 0.
REQ-011 Port i_req_addr, input, ADDR_W: byte address.
REQ-012 Port i_req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 Port o_rsp_valid, output, 1: response present.
REQ-014 Port i_rsp_ready, input, 1: consumer accepts the response.
REQ-015 Port o_rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-016 Port o_rsp_err, output, 1: access faulted; no memory write occurred.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT, RESP; o_req_ready = 1 only in IDLE.
REQ-018 A request is accepted on a rising edge with i_req_valid & o_req_ready.
  - LATENCY = 1: IDLE -> RESP.
  - LATENCY > 1: IDLE -> WAIT, counter loaded with LATENCY-2.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-020 RESP SHALL hold o_rsp_valid = 1 with stable o_rsp_rdata and o_rsp_err until i_rsp_ready = 1, then return to IDLE; no new request is accepted in that same cycle.
REQ-021 Write-enable generation:
  - byte: byte lane addr[1:0]
  - half: lanes {addr[1],1}:{addr[1],0}
  - word: all four lanes
  - data is replicated into the selected lanes.
REQ-022 A store SHALL update memory on the accept edge; unselected bytes are unchanged.
REQ-023 A load SHALL sample the addressed word on the accept edge into a holding register; the response reflects memory at acceptance.
REQ-024 Load extension:
  - byte: addressed byte extended from bit 7
  - half: addressed half extended from bit 15
  - word: unmodified
  - extension type selected by i_req_unsigned.
REQ-025 Address bits [ADDR_W-1 : clog2(DEPTH)+2] nonzero SHALL produce o_rsp_err = 1 and no write.
REQ-026 i_req_size = 11 SHALL produce o_rsp_err = 1 and no write.
REQ-027 Request inputs are sampled only on the accept edge; they are don't-care at all other times.
REQ-028 Memory is a plain array with no reset, inferable as single-port block RAM with byte enables.

Reset
REQ-029 While i_reset = 0: state = IDLE, counter = 0, o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_req_ready = 1 once reset is released.
REQ-030 Reset asserted in WAIT or RESP SHALL drop the pending response; a store already committed on its accept edge stays written.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN:
  - Defined: a half with addr[0] = 1 or a word with addr[1:0] != 00 SHALL return o_rsp_err = 1, with no write and rdata = 0.
  - Undefined: low address bits are ignored for halves (addr[0]) and words (addr[1:0]); the access is force-aligned, with no error.

Verification
REQ-032 Reset, then word store 0xDEADBEEF @0x10, then word load @0x10 with LATENCY = 1 -> o_rsp_valid one cycle after accept, rdata = 0xDEADBEEF, err = 0.
REQ-033 Byte store 0x80 @0x13, then signed byte load @0x13 -> rdata = 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
REQ-034 Half store 0x1234 @0x12; signed half load @0x12 -> 0x00001234; with i_rsp_ready held 0 for 5 cycles -> o_rsp_valid and rdata stay stable and o_req_ready = 0 throughout.
REQ-035 LATENCY = 3, load @0x0 -> o_rsp_valid asserts exactly 3 cycles after the accept edge; reset asserted during WAIT -> o_rsp_valid = 0 and o_req_ready = 1 after release.
REQ-036 DEPTH = 512, store @0x800 -> err = 1, memory unchanged; size = 11 -> err = 1.
REQ-037 Word load @0x12:
  - With DMEM_MISALIGN_TRAP_EN: err = 1, rdata = 0.
  - Without it: err = 0, data from @0x10.

Source files
------------

// File: rtl/dmem_hs_if.sv
// dmem_hs_if: request/response handshake bundle for the dmem_hs data memory.
// The slave modport is the memory side; the master modport is the requester side.
interface dmem_hs_if #(
    parameter int ADDR_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [1:0]        i_req_size;
    logic              i_req_unsigned;
    logic [ADDR_W-1:0] i_req_addr;
    logic [31:0]       i_req_wdata;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_err;

    modport slave (
        input  i_req_valid,
        output o_req_ready,
        input  i_req_we,
        input  i_req_size,
        input  i_req_unsigned,
        input  i_req_addr,
        input  i_req_wdata,
        output o_rsp_valid,
        input  i_rsp_ready,
        output o_rsp_rdata,
        output o_rsp_err
    );

    modport master (
        output i_req_valid,
        input  o_req_ready,
        output i_req_we,
        output i_req_size,
        output i_req_unsigned,
        output i_req_addr,
        output i_req_wdata,
        input  o_rsp_valid,
        output i_rsp_ready,
        input  o_rsp_rdata,
        input  o_rsp_err
    );
endinterface

// File: rtl/dmem_hs.sv
// dmem_hs: single-port byte-enabled data memory behind a valid/ready handshake.
// One request is in flight at a time (IDLE -> [WAIT] -> RESP -> IDLE).
// Stores commit on the accept edge; loads capture the addressed word on the
// accept edge and are extended when the response is presented.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (defined: misaligned half/word
// accesses fault; undefined: they are force-aligned without error).
module dmem_hs #(
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic     i_clk,
    input  logic     i_reset,
    dmem_hs_if.slave bus
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         OFF_HI   = IDX_W + 2;
    localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data into every lane it may land in.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Select the addressed byte/half from a word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rsp_valid_q;
    logic        req_ready_q;
    logic        ld_ok_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] word_q;

    logic             hi_err_s;
    logic             size_err_s;
    logic             mis_err_s;
    logic             req_err_s;
    logic             accept_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rdata_s;

    // Decode the incoming request: fault conditions, lane enables, handshake.
    always_comb begin
        hi_err_s   = (bus.i_req_addr >> OFF_HI) != {ADDR_W{1'b0}};
        size_err_s = (bus.i_req_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err_s  = ((bus.i_req_size == 2'b01) && bus.i_req_addr[0]) ||
                     ((bus.i_req_size == 2'b10) && (bus.i_req_addr[1:0] != 2'b00));
`else
        mis_err_s  = 1'b0;
`endif
        req_err_s  = hi_err_s | size_err_s | mis_err_s;
        accept_s   = bus.i_req_valid & req_ready_q;
        be_s       = lane_enables(bus.i_req_size, bus.i_req_addr[1:0]);
        wdata_s    = lane_data(bus.i_req_size, bus.i_req_wdata);
        idx_s      = bus.i_req_addr[OFF_HI-1:2];
    end

    // Next-state logic for the request/response sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= (state_d == RESP);
            req_ready_q <= (state_d == IDLE);
        end
    end

    // Capture the attributes of the accepted request for the response phase.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ld_ok_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else if (accept_s) begin
            ld_ok_q <= ~bus.i_req_we & ~req_err_s;
            err_q   <= req_err_s;
            size_q  <= bus.i_req_size;
            uns_q   <= bus.i_req_unsigned;
            off_q   <= bus.i_req_addr[1:0];
        end else begin
            ld_ok_q <= ld_ok_q;
            err_q   <= err_q;
            size_q  <= size_q;
            uns_q   <= uns_q;
            off_q   <= off_q;
        end
    end

    // Single-port RAM: byte-enabled write or word read on the accept edge only.
    always_ff @(posedge i_clk) begin
        if (accept_s && !req_err_s) begin
            if (bus.i_req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[b]) begin
                        mem[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                    end
                end
            end else begin
                word_q <= mem[idx_s];
            end
        end
    end

    // Present extended load data only while a faultless load response is valid.
    always_comb begin
        if (rsp_valid_q && ld_ok_q) begin
            rdata_s = load_extend(word_q, size_q, uns_q, off_q);
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_err   = rsp_valid_q & err_q;
    assign bus.o_rsp_rdata = rdata_s;
endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed and randomized checks of dmem_hs against a byte-array
// reference model. Two instances are exercised: LATENCY = 1 and LATENCY = 3.
module tb_dmem_hs;
    localparam int DEPTH      = 512;
    localparam int ADDR_W     = 32;
    localparam int INIT_WORDS = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dmem_hs_if #(.ADDR_W(ADDR_W)) bus1 ();
    dmem_hs_if #(.ADDR_W(ADDR_W)) bus3 ();

    dmem_hs #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus1)
    );

    dmem_hs #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(3)) dut3 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus3)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [2][DEPTH*4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed memory, natural alignment by size.
    function automatic void model(input int s, input logic we, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int nbytes;
        int base;
        logic [31:0] v;
        err   = (size == 2'd3) || (addr >= 32'(DEPTH*4));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (size == 2'd1 && addr % 2 != 0) err = 1'b1;
        if (size == 2'd2 && addr % 4 != 0) err = 1'b1;
`endif
        rdata = 32'h0;
        if (err) return;
        nbytes = 1 << size;
        base   = int'(addr) / nbytes * nbytes;
        if (we) begin
            for (int i = 0; i < nbytes; i++) ref_mem[s][base+i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[s][base+i];
            if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v - (32'd1 << (8*nbytes));
            rdata = v;
        end
    endfunction

    function automatic logic rsp_valid(input int s);
        return (s == 0) ? bus1.o_rsp_valid : bus3.o_rsp_valid;
    endfunction
    function automatic logic req_ready(input int s);
        return (s == 0) ? bus1.o_req_ready : bus3.o_req_ready;
    endfunction
    function automatic logic [31:0] rsp_rdata(input int s);
        return (s == 0) ? bus1.o_rsp_rdata : bus3.o_rsp_rdata;
    endfunction
    function automatic logic rsp_err(input int s);
        return (s == 0) ? bus1.o_rsp_err : bus3.o_rsp_err;
    endfunction

    task automatic drive(input int s, input logic v, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (s == 0) begin
            bus1.i_req_valid = v; bus1.i_req_we = we; bus1.i_req_size = size;
            bus1.i_req_unsigned = uns; bus1.i_req_addr = addr; bus1.i_req_wdata = wdata;
        end else begin
            bus3.i_req_valid = v; bus3.i_req_we = we; bus3.i_req_size = size;
            bus3.i_req_unsigned = uns; bus3.i_req_addr = addr; bus3.i_req_wdata = wdata;
        end
    endtask

    task automatic set_rsp_ready(input int s, input logic v);
        if (s == 0) bus1.i_rsp_ready = v;
        else        bus3.i_rsp_ready = v;
    endtask

    // One full transaction: issue, measure latency, optionally stall, complete.
    task automatic access(input int s, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] got_d, output logic got_e);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!req_ready(s) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_idle", {31'd0, req_ready(s)}, 32'd1);
        drive(s, 1'b1, we, size, uns, addr, wdata);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid(s) && cyc < 20);
        check("latency", 32'(cyc), (s == 0) ? 32'd1 : 32'd3);
        got_d = rsp_rdata(s);
        got_e = rsp_err(s);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rsp_valid(s)}, 32'd1);
            check("stall_rdata", rsp_rdata(s), got_d);
            check("stall_err",   {31'd0, rsp_err(s)}, {31'd0, got_e});
            check("stall_ready", {31'd0, req_ready(s)}, 32'd0);
        end
        set_rsp_ready(s, 1'b1);
        @(posedge clk);
        #1;
        set_rsp_ready(s, 1'b0);
        @(negedge clk);
        check("ready_after_rsp", {31'd0, req_ready(s)}, 32'd1);
        check("valid_after_rsp", {31'd0, rsp_valid(s)}, 32'd0);
    endtask

    // Transaction plus comparison against the reference model.
    task automatic op(input int s, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] got_d, output logic got_e);
        logic        exp_e;
        logic [31:0] exp_d;
        model(s, we, size, uns, addr, wdata, exp_e, exp_d);
        access(s, we, size, uns, addr, wdata, hold, got_d, got_e);
        check("model_err",   {31'd0, got_e}, {31'd0, exp_e});
        check("model_rdata", got_d, exp_d);
    endtask

    task automatic random_ops(input int s, input int n);
        logic [31:0] d;
        logic        e;
        logic [1:0]  size;
        logic [31:0] addr;
        int          r;
        for (int k = 0; k < n; k++) begin
            r    = int'($urandom_range(0, 19));
            size = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r == 1)      addr = 32'h800 + 32'($urandom_range(0, 4095));
            else if (r == 2) addr = $urandom;
            else             addr = 32'($urandom_range(0, INIT_WORDS*4 - 1));
            op(s, 1'($urandom), size, 1'($urandom), addr, $urandom,
               int'($urandom_range(0, 2)), d, e);
        end
    endtask

    logic [31:0] d;
    logic        e;

    initial begin
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid1", {31'd0, bus1.o_rsp_valid}, 32'd0);
        check("rst_rdata1", bus1.o_rsp_rdata, 32'd0);
        check("rst_err1",   {31'd0, bus1.o_rsp_err}, 32'd0);
        check("rst_valid3", {31'd0, bus3.o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready1", {31'd0, bus1.o_req_ready}, 32'd1);
        check("rst_ready3", {31'd0, bus3.o_req_ready}, 32'd1);

        // Give both memories known contents in the exercised region.
        for (int w = 0; w < INIT_WORDS; w++) begin
            op(0, 1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, 0, d, e);
            op(1, 1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, 0, d, e);
        end

        // Word store and load.
        op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, d, e);
        op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, d, e);
        check("word_load", d, 32'hDEADBEEF);
        check("word_load_err", {31'd0, e}, 32'd0);

        // Byte store with junk in the upper bits, signed/unsigned loads.
        op(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'hAAAAAA80, 0, d, e);
        op(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, d, e);
        check("byte_signed", d, 32'hFFFFFF80);
        op(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, d, e);
        check("byte_unsigned", d, 32'h00000080);
        op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, d, e);
        check("byte_merge", d, 32'h80ADBEEF);

        // Half store, signed half load with a 5-cycle response stall.
        op(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h55551234, 0, d, e);
        op(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5, d, e);
        check("half_signed", d, 32'h00001234);

        // Out-of-range store and illegal size fault without writing.
        op(0, 1'b1, 2'd2, 1'b0, 32'h800, 32'hCAFEF00D, 0, d, e);
        check("range_err", {31'd0, e}, 32'd1);
        op(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, d, e);
        op(0, 1'b1, 2'd3, 1'b0, 32'h20, 32'h12345678, 0, d, e);
        check("size_err", {31'd0, e}, 32'd1);
        check("size_err_rdata", d, 32'd0);
        op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, d, e);

        // Misaligned word load.
        op(0, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, d, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign_err", {31'd0, e}, 32'd1);
        check("misalign_rdata", d, 32'd0);
`else
        check("misalign_err", {31'd0, e}, 32'd0);
        check("misalign_rdata", d, 32'h1234BEEF);
`endif

        // Randomized traffic on both latencies.
        random_ops(0, 300);
        random_ops(1, 60);

        // Reset while the LATENCY = 3 instance is in WAIT drops the response.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("wait_no_valid", {31'd0, bus3.o_rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_wait_valid", {31'd0, bus3.o_rsp_valid}, 32'd0);
        check("rst_wait_rdata", bus3.o_rsp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_wait_still", {31'd0, bus3.o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", {31'd0, bus3.o_req_ready}, 32'd1);
        check("rst_wait_valid2", {31'd0, bus3.o_rsp_valid}, 32'd0);

        // Memory survives reset and the instance resumes normal operation.
        op(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, d, e);
        random_ops(1, 20);
        random_ops(0, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
